even_zeroes_imp: RTL and testbench



---
 rtl/even_zeroes_imp.sv | 107 ++++++++++
 tb/tb_even_zeroes_imp.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/even_zeroes_imp.sv
// Dual-rail four-phase even-zeroes parity tracker with registered dual-rail reply.
// Optional SYNC_EN: adds a 2-flop synchronizer on each input rail (latency 1 -> 3 cycles).
module even_zeroes_imp #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit0,
  input  logic             bit1,
  output logic             parity0,
  output logic             parity1,
  output logic             err,
  output logic [CNT_W-1:0] tok_cnt
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [1:0] CODE_SP  = 2'b00;
  localparam logic [1:0] CODE_D0  = 2'b01;
  localparam logic [1:0] CODE_D1  = 2'b10;
  localparam logic [1:0] CODE_ILL = 2'b11;

  logic [1:0] code;

`ifdef SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bit1, bit0};
      sync2_q <= sync1_q;
    end
  end

  assign code = sync2_q;
`else
  assign code = {bit1, bit0};
`endif

  state_t           state_q;
  logic             even_q;
  logic [1:0]       tok_q;
  logic             parity0_q;
  logic             parity1_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  // tok_q remembers the accepted code so HOLD can tell "same token" from a rail switch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      even_q    <= 1'b1;
      tok_q     <= CODE_SP;
      parity0_q <= 1'b0;
      parity1_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (code)
            CODE_D0: begin
              state_q   <= HOLD;
              even_q    <= ~even_q;
              tok_q     <= code;
              parity1_q <= ~even_q;
              parity0_q <= even_q;
              cnt_q     <= cnt_q + 1'b1;
            end
            CODE_D1: begin
              state_q   <= HOLD;
              tok_q     <= code;
              parity1_q <= even_q;
              parity0_q <= ~even_q;
              cnt_q     <= cnt_q + 1'b1;
            end
            CODE_ILL: err_q <= 1'b1;
            default: ;
          endcase
        end
        HOLD: begin
          if (code == CODE_SP) begin
            state_q   <= IDLE;
            parity0_q <= 1'b0;
            parity1_q <= 1'b0;
          end else if (code != tok_q) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign parity0 = parity0_q;
  assign parity1 = parity1_q;
  assign err     = err_q;
  assign tok_cnt = cnt_q;

endmodule

// File: tb/tb_even_zeroes_imp.sv
// Directed self-checking bench for even_zeroes_imp (default width plus a CNT_W=2 wrap instance).
module tb_even_zeroes_imp;

`ifdef SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit0 = 1'b0;
  logic       bit1 = 1'b0;
  logic       parity0, parity1, err;
  logic [7:0] tok_cnt;
  logic       s_parity0, s_parity1, s_err;
  logic [1:0] s_tok_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  even_zeroes_imp #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit0(bit0), .bit1(bit1),
    .parity0(parity0), .parity1(parity1), .err(err), .tok_cnt(tok_cnt)
  );

  even_zeroes_imp #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .bit0(bit0), .bit1(bit1),
    .parity0(s_parity0), .parity1(s_parity1), .err(s_err), .tok_cnt(s_tok_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c);
    {bit1, bit0} = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00);
    step(LAT + 1);
    rst_n = 1'b1;
  endtask

  // One full handshake: token, check reply rails, spacer, check return to zero.
  task automatic token(input string tag, input logic [1:0] c, input logic e0, input logic e1);
    drive(c);
    step(LAT);
    chk({tag, "_p0"}, parity0, e0);
    chk({tag, "_p1"}, parity1, e1);
    drive(2'b00);
    step(LAT);
    chk({tag, "_rz0"}, parity0, 1'b0);
    chk({tag, "_rz1"}, parity1, 1'b0);
  endtask

  initial begin
    // reset state
    step(2);
    chk("rst_p0", parity0, 1'b0);
    chk("rst_p1", parity1, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", tok_cnt, 8'd0);
    step(LAT);
    rst_n = 1'b1;

    // first data0: reply appears exactly LAT cycles after input change
    drive(2'b01);
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk($sformatf("lat_p0_%0d", i), parity0, (i == LAT));
    end
    chk("d0_p1", parity1, 1'b0);
    chk("d0_cnt", tok_cnt, 8'd1);
    drive(2'b00);
    step(LAT);
    chk("sp_p0", parity0, 1'b0);
    chk("sp_p1", parity1, 1'b0);

    // sequence data0, data0, data1, data0, data1
    do_reset();
    token("seq1", 2'b01, 1'b1, 1'b0);
    token("seq2", 2'b01, 1'b0, 1'b1);
    token("seq3", 2'b10, 1'b0, 1'b1);
    token("seq4", 2'b01, 1'b1, 1'b0);
    chk("seq_cnt4", tok_cnt, 8'd4);
    chk("wrap_cnt4", s_tok_cnt, 2'd0);
    token("seq5", 2'b10, 1'b1, 1'b0);
    chk("seq_cnt5", tok_cnt, 8'd5);
    chk("wrap_cnt5", s_tok_cnt, 2'd1);
    chk("seq_err", err, 1'b0);

    // illegal code in IDLE, then valid data1
    do_reset();
    drive(2'b11);
    step(LAT);
    chk("ill_err", err, 1'b1);
    chk("ill_p0", parity0, 1'b0);
    chk("ill_p1", parity1, 1'b0);
    chk("ill_cnt", tok_cnt, 8'd0);
    drive(2'b00);
    step(LAT);
    token("ill_d1", 2'b10, 1'b0, 1'b1);
    chk("ill_err_sticky", err, 1'b1);
    chk("ill_cnt1", tok_cnt, 8'd1);

    // rail switch in HOLD, then reset mid-HOLD
    do_reset();
    drive(2'b01);
    step(LAT);
    step(2);
    chk("hold_p0", parity0, 1'b1);
    chk("hold_err", err, 1'b0);
    drive(2'b10);
    step(LAT);
    chk("sw_err", err, 1'b1);
    chk("sw_p0", parity0, 1'b1);
    chk("sw_p1", parity1, 1'b0);
    chk("sw_cnt", tok_cnt, 8'd1);
    rst_n = 1'b0;
    step(1);
    chk("mrst_p0", parity0, 1'b0);
    chk("mrst_p1", parity1, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_cnt", tok_cnt, 8'd0);
    drive(2'b00);
    step(LAT);
    rst_n = 1'b1;
    token("mrst_even", 2'b01, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
